// File: rtl/fft_sdf_stage.sv
// Radix-2 DIF single-path-delay-feedback FFT stage.
// D-deep complex feedback FIFO; differences are twiddled on the way in.
module fft_sdf_stage #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int LOG2_D = 3,
  parameter int SCALE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              in_ready,
  input  logic              flush,
  output logic [LOG2_D-1:0] tw_idx,
  input  logic [DATA_W-1:0] tw_re,
  input  logic [DATA_W-1:0] tw_im,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im
);

  localparam int D  = 1 << LOG2_D;
  localparam int CW = LOG2_D + 1;
  localparam int W2 = 2 * DATA_W;

  localparam logic [CW-1:0] HALF_LAST = CW'(D - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(2 * D - 1);

  typedef enum logic [1:0] {
    FILL,
    BFLY,
    DRAIN
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              pending;
  logic [LOG2_D-1:0] ptr;
  logic [W2-1:0]     mem [D];
  logic [W2-1:0]     head;
  logic              acc;
  logic              push;
  logic [W2-1:0]     push_data;

  logic [DATA_W-1:0] a_re, a_im;
  logic [DATA_W-1:0] sum_re, sum_im;
  logic [DATA_W-1:0] dif_re, dif_im;
  logic [DATA_W-1:0] prod_re, prod_im;

  logic signed [W2-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [W2:0]   p_re, p_im;
  logic signed [W2:0]   q_re, q_im;

  function automatic logic [DATA_W-1:0] add_sc(
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] y,
    input logic              sub
  );
    logic signed [DATA_W:0] t;
    if (sub) t = $signed({x[DATA_W-1], x}) - $signed({y[DATA_W-1], y});
    else     t = $signed({x[DATA_W-1], x}) + $signed({y[DATA_W-1], y});
    if (SCALE == 1) t = t >>> 1;
    return t[DATA_W-1:0];
  endfunction

  function automatic logic signed [W2-1:0] mul(
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] y
  );
    return $signed({{DATA_W{x[DATA_W-1]}}, x}) *
           $signed({{DATA_W{y[DATA_W-1]}}, y});
  endfunction

  assign head     = mem[ptr];
  assign a_re     = head[W2-1:DATA_W];
  assign a_im     = head[DATA_W-1:0];
  assign in_ready = (state != DRAIN);
  assign acc      = in_valid && in_ready;
  assign tw_idx   = (state == BFLY) ? cnt[LOG2_D-1:0] : '0;

  assign sum_re = add_sc(a_re, in_re, 1'b0);
  assign sum_im = add_sc(a_im, in_im, 1'b0);
  assign dif_re = add_sc(a_re, in_re, 1'b1);
  assign dif_im = add_sc(a_im, in_im, 1'b1);

  assign m_rr = mul(dif_re, tw_re);
  assign m_ii = mul(dif_im, tw_im);
  assign m_ri = mul(dif_re, tw_im);
  assign m_ir = mul(dif_im, tw_re);

  // Full-width combine, floor shift, then wrap to DATA_W.
  assign p_re    = $signed({m_rr[W2-1], m_rr}) - $signed({m_ii[W2-1], m_ii});
  assign p_im    = $signed({m_ri[W2-1], m_ri}) + $signed({m_ir[W2-1], m_ir});
  assign q_re    = p_re >>> FRAC_W;
  assign q_im    = p_im >>> FRAC_W;
  assign prod_re = q_re[DATA_W-1:0];
  assign prod_im = q_im[DATA_W-1:0];

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (!rst) begin
      unique case (1'b1)
        state == FILL: begin
          push      = acc;
          push_data = {in_re, in_im};
        end
        state == BFLY: begin
          push      = acc;
          push_data = {prod_re, prod_im};
        end
        state == DRAIN: begin
          push      = 1'b1;
          push_data = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      cnt       <= '0;
      pending   <= 1'b0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      out_valid <= 1'b0;
      if (push) ptr <= ptr + 1'b1;
      unique case (state)
        FILL: begin
          if (acc) begin
            if (pending) begin
              out_valid <= 1'b1;
              out_re    <= a_re;
              out_im    <= a_im;
            end
            cnt <= cnt + 1'b1;
            if (cnt == HALF_LAST) state <= BFLY;
          end else if (cnt == '0 && pending && flush) begin
            state <= DRAIN;
          end
        end
        BFLY: begin
          if (acc) begin
            out_valid <= 1'b1;
            out_re    <= sum_re;
            out_im    <= sum_im;
            if (cnt == FULL_LAST) begin
              cnt     <= '0;
              pending <= 1'b1;
              state   <= FILL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          out_valid <= 1'b1;
          out_re    <= a_re;
          out_im    <= a_im;
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            pending <= 1'b0;
            state   <= FILL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_sdf_stage.sv
// Directed bench for fft_sdf_stage, D = 8, Q16.16.
// Two instances share stimulus: SCALE = 0 and SCALE = 1.
module tb_fft_sdf_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_re, in_im;
  logic        flush;

  logic        rdy0, rdy1;
  logic [2:0]  twi0, twi1;
  logic [31:0] twr0_v, twi0_v, twr1_v, twi1_v;
  logic        ov0, ov1;
  logic [31:0] ore0, oim0, ore1, oim1;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];

  always #5 clk = ~clk;

  // W16^k, magnitudes truncated toward zero
  function automatic logic [63:0] tw(input logic [2:0] k);
    case (k)
      3'd0: return {32'h00010000, 32'h00000000};
      3'd1: return {32'h0000EC83, 32'hFFFF9E09};
      3'd2: return {32'h0000B504, 32'hFFFF4AFC};
      3'd3: return {32'h000061F7, 32'hFFFF137D};
      3'd4: return {32'h00000000, 32'hFFFF0000};
      3'd5: return {32'hFFFF9E09, 32'hFFFF137D};
      3'd6: return {32'hFFFF4AFC, 32'hFFFF4AFC};
      default: return {32'hFFFF137D, 32'hFFFF9E09};
    endcase
  endfunction

  assign {twr0_v, twi0_v} = tw(twi0);
  assign {twr1_v, twi1_v} = tw(twi1);

  fft_sdf_stage #(.DATA_W(32), .FRAC_W(16), .LOG2_D(3), .SCALE(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re),
    .in_im(in_im), .in_ready(rdy0), .flush(flush), .tw_idx(twi0),
    .tw_re(twr0_v), .tw_im(twi0_v), .out_valid(ov0),
    .out_re(ore0), .out_im(oim0)
  );

  fft_sdf_stage #(.DATA_W(32), .FRAC_W(16), .LOG2_D(3), .SCALE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re),
    .in_im(in_im), .in_ready(rdy1), .flush(flush), .tw_idx(twi1),
    .tw_re(twr1_v), .tw_im(twi1_v), .out_valid(ov1),
    .out_re(ore1), .out_im(oim1)
  );

  always @(negedge clk) begin
    if (ov0) q0.push_back({ore0, oim0});
    if (ov1) q1.push_back({ore1, oim1});
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    in_re    = '0;
    in_im    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One 16-sample frame back-to-back, then flush and drain.
  task automatic run_frame(input int ia, input logic [31:0] ar,
                           input logic [31:0] ai, input int ib,
                           input logic [31:0] br, input bit hold,
                           output int drain_len);
    int low;
    q0.delete();
    q1.delete();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_re = (i == ia) ? ar : ((i == ib) ? br : 32'h0);
      in_im = (i == ia) ? ai : 32'h0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
    flush    = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    low   = 0;
    for (int c = 0; c < 24; c++) begin
      if (!rdy0) begin
        low++;
        if (hold) begin
          in_valid = 1'b1;
          in_re    = 32'h12345678;
          in_im    = 32'h0BADF00D;
        end
      end else begin
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;
        if (low > 0) break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    drain_len = low;
  endtask

  typedef struct {
    string       nm;
    int          ia;
    logic [31:0] ar;
    logic [31:0] ai;
    int          ib;
    logic [31:0] br;
    bit          sc;
    int          h1;
    logic [63:0] v1;
    int          h2;
    logic [63:0] v2;
  } vec_t;

  vec_t vt[9];

  task automatic check_frame(input string nm, input bit sc,
                             input int h1, input logic [63:0] v1,
                             input int h2, input logic [63:0] v2);
    logic [63:0] e;
    logic [63:0] a;
    int sz;
    sz = sc ? q1.size() : q0.size();
    chk({nm, ".count"}, 64'(sz), 64'd16);
    for (int k = 0; k < 16; k++) begin
      e = (k == h1) ? v1 : ((k == h2) ? v2 : 64'h0);
      a = (k < sz) ? (sc ? q1[k] : q0[k]) : 64'hDEAD_DEAD_DEAD_DEAD;
      chk($sformatf("%s.out%0d", nm, k), a, e);
    end
  endtask

  initial begin
    int dl;
    int gap;
    int qs;
    logic [63:0] e;

    vt[0] = '{"imp0", 0, 32'h00010000, 32'h0, -1, 32'h0, 1'b0,
              0, {32'h00010000, 32'h0}, 8, {32'h00010000, 32'h0}};
    vt[1] = '{"imp1", 1, 32'h00010000, 32'h0, -1, 32'h0, 1'b0,
              1, {32'h00010000, 32'h0}, 9, {32'h0000EC83, 32'hFFFF9E09}};
    vt[2] = '{"imp2j", 2, 32'h0, 32'h00010000, -1, 32'h0, 1'b0,
              2, {32'h0, 32'h00010000}, 10, {32'h0000B504, 32'h0000B504}};
    vt[3] = '{"imp8", -1, 32'h0, 32'h0, 8, 32'h00010000, 1'b0,
              0, {32'h00010000, 32'h0}, 8, {32'hFFFF0000, 32'h0}};
    vt[4] = '{"imp13", -1, 32'h0, 32'h0, 13, 32'h00010000, 1'b0,
              5, {32'h00010000, 32'h0}, 13, {32'h000061F7, 32'h0000EC83}};
    vt[5] = '{"half4", 4, 32'h00008000, 32'h0, -1, 32'h0, 1'b0,
              4, {32'h00008000, 32'h0}, 12, {32'h0, 32'hFFFF8000}};
    vt[6] = '{"floor3", 3, 32'h00000001, 32'h0, -1, 32'h0, 1'b0,
              3, {32'h00000001, 32'h0}, 11, {32'h0, 32'hFFFFFFFF}};
    vt[7] = '{"wrap", 0, 32'h7FFFFFFF, 32'h0, 8, 32'h7FFFFFFF, 1'b0,
              0, {32'hFFFFFFFE, 32'h0}, -1, 64'h0};
    vt[8] = '{"scale", 0, 32'h7FFFFFFF, 32'h0, 8, 32'h7FFFFFFF, 1'b1,
              0, {32'h7FFFFFFF, 32'h0}, -1, 64'h0};

    do_reset();
    chk("rst.out_valid", 64'(ov0), 64'd0);
    chk("rst.out_re", 64'(ore0), 64'd0);
    chk("rst.out_im", 64'(oim0), 64'd0);
    chk("rst.in_ready", 64'(rdy0), 64'd1);
    chk("rst.tw_idx", 64'(twi0), 64'd0);

    for (int v = 0; v < 9; v++) begin
      do_reset();
      run_frame(vt[v].ia, vt[v].ar, vt[v].ai, vt[v].ib, vt[v].br,
                1'b0, dl);
      chk({vt[v].nm, ".drain_len"}, 64'(dl), 64'd8);
      check_frame(vt[v].nm, vt[v].sc, vt[v].h1, vt[v].v1,
                  vt[v].h2, vt[v].v2);
    end

    // Two constant frames with random input gaps.
    do_reset();
    q0.delete();
    for (int i = 0; i < 32; i++) begin
      gap = $urandom_range(0, 2);
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_re    = 32'h00010000;
      in_im    = 32'h0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("gaps.count", 64'(q0.size()), 64'd24);
    for (int k = 0; k < 24; k++) begin
      e = (k >= 8 && k < 16) ? 64'h0 : {32'h00020000, 32'h0};
      chk($sformatf("gaps.out%0d", k),
          (k < q0.size()) ? q0[k] : 64'hDEAD_DEAD_DEAD_DEAD, e);
    end

    // Reset in BFLY at cnt = 11, then a fresh impulse frame.
    do_reset();
    q0.delete();
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      in_re    = 32'h00030000;
      in_im    = 32'h0;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    qs       = q0.size();
    chk("midrst.sums_before", 64'(qs), 64'd3);
    flush = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("midrst.flush_ignored", 64'(rdy0), 64'd1);
    end
    flush = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst.no_out", 64'(q0.size()), 64'(qs));

    run_frame(0, 32'h00010000, 32'h0, -1, 32'h0, 1'b1, dl);
    chk("midrst.drain_len", 64'(dl), 64'd8);
    check_frame("midrst", 1'b0, 0, {32'h00010000, 32'h0},
                8, {32'h00010000, 32'h0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
